// File: rtl/axi_write_stream.sv
// axi_write_stream
// ----------------
// AXI4 write master fed by a valid/ready stream. Incoming words are buffered
// in a first-word-fall-through FIFO. Once a whole burst (WR_LIN words) is
// buffered, a fixed-length INCR burst is written at the current block address.
// The block address then steps by WR_STRIDE and wraps to 0 inside
// WR_ADDR_RANGE. Only one burst is in flight at a time.
//
// Ports:
//   M_WR_aclk, M_WR_areset     clock, synchronous active-high reset
//   S_WR_tdata/tvalid/tready   input stream
//   o_wr_done                  one-cycle pulse after each burst's write response
//   o_wr_err                   pulses with o_wr_done when bresp was non-zero
//   m_axi_aw*                  write address channel (constant fields tied off)
//   m_axi_w*                   write data channel
//   m_axi_b*                   write response channel (bid ignored)
//   dbg_state                  current FSM state, for observation only
//
// Handshake rule used on every channel: a transfer happens on a rising clock
// edge where valid and ready are both high. Once a valid is raised, it and its
// payload hold until that transfer completes.
module axi_write_stream #(
   parameter int          WR_FLIP_BYTE  = 0,
   parameter int          WR_ADDR_WIDTH = 32,
   parameter int          WR_DATA_WIDTH = 64,
   parameter int          WR_LIN        = 16,
   parameter logic [31:0] WR_STRIDE     = 32'd4096,
   parameter logic [31:0] WR_ADDR_RANGE = 32'h10000,
   parameter int          FIFO_DEPTH    = 32
) (
   input  logic                       M_WR_aclk,
   input  logic                       M_WR_areset,
   input  logic [WR_DATA_WIDTH-1:0]   S_WR_tdata,
   input  logic                       S_WR_tvalid,
   output logic                       S_WR_tready,
   output logic                       o_wr_done,
   output logic                       o_wr_err,
   output logic                       m_axi_awid,
   output logic                       m_axi_awlock,
   output logic [2:0]                 m_axi_awprot,
   output logic [3:0]                 m_axi_awqos,
   output logic [3:0]                 m_axi_awcache,
   output logic [WR_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]                 m_axi_awlen,
   output logic [2:0]                 m_axi_awsize,
   output logic [1:0]                 m_axi_awburst,
   output logic                       m_axi_awvalid,
   input  logic                       m_axi_awready,
   output logic [WR_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [WR_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                       m_axi_wlast,
   output logic                       m_axi_wvalid,
   input  logic                       m_axi_wready,
   input  logic                       m_axi_bid,
   input  logic [1:0]                 m_axi_bresp,
   input  logic                       m_axi_bvalid,
   output logic                       m_axi_bready,
   output logic [2:0]                 dbg_state
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NB = WR_DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      WAIT_WR = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      WR_RESP = 3'd3,
      WR_STOP = 3'd4
   } state_t;

   state_t state, state_next;

   // ---------------- FIFO ----------------
   logic [WR_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]            wr_ptr, rd_ptr;
   logic [PW:0]              count;
   logic                     full, push, pop;
   logic [WR_DATA_WIDTH-1:0] head, head_flip;

   assign full        = (count == (PW+1)'(FIFO_DEPTH));
   assign S_WR_tready = !full && !M_WR_areset;
   assign push        = S_WR_tvalid && S_WR_tready;
   assign pop         = m_axi_wvalid && m_axi_wready;
   assign head        = mem[rd_ptr];

   always_ff @(posedge M_WR_aclk) begin
      if (M_WR_areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         // Push and pop together leave the count where it is.
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; push is already blocked while reset is high.
   always_ff @(posedge M_WR_aclk) begin
      if (push) mem[wr_ptr] <= S_WR_tdata;
   end

   // Optional byte reversal of each beat on its way to AXI.
   always_comb begin
      head_flip = head;
      if (WR_FLIP_BYTE != 0) begin
         for (int b = 0; b < NB; b++) begin
            head_flip[8*b +: 8] = head[8*(NB-1-b) +: 8];
         end
      end
   end

   // ---------------- FSM ----------------
   logic [7:0]               beat;
   logic [31:0]              addr_q;
   logic [1:0]               bresp_q;
   logic [WR_ADDR_WIDTH-1:0] awaddr_q;
   logic [7:0]               awlen_q;
   logic [2:0]               awsize_q;
   logic [1:0]               awburst_q;

   always_comb begin
      state_next    = state;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wlast   = 1'b0;
      m_axi_bready  = 1'b0;
      o_wr_done     = 1'b0;
      o_wr_err      = 1'b0;
      case (state)
         WAIT_WR: begin
            // Waiting for a whole burst guarantees W never starves mid-burst.
            if (count >= (PW+1)'(WR_LIN)) state_next = WR_ADDR;
         end
         WR_ADDR: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) state_next = WR_DATA;
         end
         WR_DATA: begin
            m_axi_wvalid = 1'b1;
            m_axi_wlast  = (beat == 8'(WR_LIN - 1));
            if (m_axi_wready && m_axi_wlast) state_next = WR_RESP;
         end
         WR_RESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) state_next = WR_STOP;
         end
         WR_STOP: begin
            o_wr_done  = 1'b1;
            o_wr_err   = (bresp_q != 2'b00);
            state_next = WAIT_WR;
         end
         default: state_next = WAIT_WR;
      endcase
   end

   always_ff @(posedge M_WR_aclk) begin
      if (M_WR_areset) begin
         state     <= WAIT_WR;
         beat      <= '0;
         addr_q    <= '0;
         bresp_q   <= '0;
         awaddr_q  <= '0;
         awlen_q   <= '0;
         awsize_q  <= '0;
         awburst_q <= '0;
      end else begin
         state <= state_next;
         // AW fields are captured as the burst is launched and hold afterwards.
         if (state == WAIT_WR && state_next == WR_ADDR) begin
            awaddr_q  <= addr_q[WR_ADDR_WIDTH-1:0];
            awlen_q   <= 8'(WR_LIN - 1);
            awsize_q  <= 3'($clog2(NB));
            awburst_q <= 2'b01;
         end
         if (pop) beat <= m_axi_wlast ? 8'd0 : beat + 8'd1;
         if (m_axi_bvalid && m_axi_bready) bresp_q <= m_axi_bresp;
         if (state == WR_STOP) begin
            addr_q <= (addr_q >= WR_ADDR_RANGE - WR_STRIDE) ? 32'd0 : addr_q + WR_STRIDE;
         end
      end
   end

   // ---------------- outputs ----------------
   assign m_axi_awid    = 1'b0;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awprot  = 3'd0;
   assign m_axi_awqos   = 4'd0;
   assign m_axi_awcache = 4'd3;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awlen   = awlen_q;
   assign m_axi_awsize  = awsize_q;
   assign m_axi_awburst = awburst_q;
   assign m_axi_wdata   = head_flip;
   assign m_axi_wstrb   = '1;
   assign dbg_state     = state;

   logic unused_bid;
   assign unused_bid = m_axi_bid;

endmodule

// File: doc/axi_write_stream.md
Name: axi_write_stream

Overview:
AXI4 write master that accepts a valid/ready data stream, buffers it in an internal FIFO, and writes it to memory as fixed-length INCR bursts at stepping addresses. It is the write-side counterpart of the stream read master. Its one-cycle o_wr_done pulse, issued after each burst's write response, drives the read master's i_wr_done input, so a block is read back only after it is committed.

Parameters:
WR_FLIP_BYTE, 0, 1 = byte-reverse each beat toward AXI (32/64/128-bit widths only)
WR_ADDR_WIDTH, 32, AXI address width
WR_DATA_WIDTH, 64, data width: 32, 64 or 128
WR_LIN, 16, beats per burst, 1-256
WR_STRIDE, 4096, byte address step between bursts
WR_ADDR_RANGE, 32'h10000, address window size; addresses wrap to 0
FIFO_DEPTH, 32, buffer depth in words, power of 2, >= WR_LIN

Ports:
M_WR_aclk  in  1  sole clock (stream and AXI)
M_WR_areset  in  1  synchronous, active-high reset
S_WR_tdata  in  WR_DATA_WIDTH  stream data
S_WR_tvalid  in  1  stream valid
S_WR_tready  out  1  stream ready
o_wr_done  out  1  one-cycle pulse: burst committed
o_wr_err  out  1  one-cycle pulse with o_wr_done when bresp != 0
m_axi_awid/awlock/awprot/awqos  out  1/1/3/4  constant 0
m_axi_awcache  out  4  constant 3
m_axi_awaddr  out  WR_ADDR_WIDTH  burst address
m_axi_awlen  out  8  WR_LIN-1
m_axi_awsize  out  3  log2(WR_DATA_WIDTH/8)
m_axi_awburst  out  2  2'b01 (INCR)
m_axi_awvalid / m_axi_awready  out/in  1  AW handshake
m_axi_wdata  out  WR_DATA_WIDTH  write data
m_axi_wstrb  out  WR_DATA_WIDTH/8  all ones
m_axi_wlast  out  1  last beat of burst
m_axi_wvalid / m_axi_wready  out/in  1  W handshake
m_axi_bid  in  1  ignored
m_axi_bresp  in  2  write response
m_axi_bvalid / m_axi_bready  in/out  1  B handshake

Behaviour:
- Reset, sampled on the M_WR_aclk edge:
  - FIFO is emptied; write address register and beat counter go to 0; state goes to WAIT_WR.
  - awvalid, wvalid, wlast, bready, o_wr_done and o_wr_err are 0.
  - awaddr, awlen, awsize and awburst are 0.
  - S_WR_tready is forced to 0 while M_WR_areset is high.
- Reset mid-burst abandons the AXI transaction without completing it; system-level reset of the slave is required.
- FIFO:
  - First-word-fall-through, with a count of 0..FIFO_DEPTH.
  - Push on S_WR_tvalid && S_WR_tready; S_WR_tready = !full.
  - Pop on m_axi_wvalid && m_axi_wready.
  - Simultaneous push and pop leaves the count unchanged, including when full (tready stays 0 when full; no push occurs at full).
- FSM states:
  - WAIT_WR: go to WR_ADDR when count >= WR_LIN. The whole burst is buffered before AW is issued, so W never stalls on the master side.
  - WR_ADDR: awvalid = 1; awaddr = addr register; awlen, awsize and awburst are loaded. On awready, awvalid drops the next cycle and the FSM goes to WR_DATA.
  - WR_DATA:
    - wvalid = 1, wdata = FIFO head (byte-flipped if WR_FLIP_BYTE).
    - The beat counter increments on each W handshake.
    - wlast = (beat counter == WR_LIN-1); with WR_LIN = 1, wlast = 1 on the only beat.
    - When wlast is handshaked, go to WR_RESP and clear the beat counter.
  - WR_RESP: bready = 1; go to WR_STOP on bvalid.
  - WR_STOP, one cycle:
    - o_wr_done = 1; o_wr_err = (captured bresp != 0).
    - The addr register advances: if addr >= WR_ADDR_RANGE - WR_STRIDE then 0, else addr + WR_STRIDE.
    - Go to WAIT_WR.
- awvalid and wvalid are never asserted together. AW completes strictly before the first W beat.
- Exactly one burst is outstanding at a time.
- Stream input keeps filling the FIFO in every state.
- Minimum latency:
  - From count reaching WR_LIN to awvalid: 1 cycle.
  - From bvalid to o_wr_done: 1 cycle.
- Address arithmetic uses a 32-bit register, truncated to WR_ADDR_WIDTH on output.

Test Plan:
1. Defaults, 16 words streamed back-to-back, awready/wready/bvalid always 1 -> one AW with awaddr 0x0, awlen 15, awsize 3, awburst 1; 16 W beats with wlast on beat 16 only; o_wr_done pulses once; next burst address is 0x1000.
2. 15 words pushed, then a pause of 20 cycles -> no awvalid; the 16th word triggers awvalid 1 cycle later.
3. 16 bursts streamed continuously -> addresses 0x0, 0x1000 … 0xF000; the 17th burst wraps to 0x0; each burst yields exactly one o_wr_done.
4. awready held 0 for 10 cycles, then wready toggling 1/0, with 40 words streamed -> awvalid stays high until accepted; FIFO reaches 32 and S_WR_tready drops to 0; no data is lost or reordered; the word sequence on W matches the input.
5. bresp = 2'b10 on one burst -> o_wr_err and o_wr_done pulse in the same cycle; the next burst proceeds normally.
6. Reset asserted on W beat 8 of a burst, then released -> all AXI valids are 0 one edge later; FIFO is empty; S_WR_tready = 1; the next burst starts at awaddr 0x0. With WR_FLIP_BYTE = 1, input 64'h0102030405060708 appears as wdata 64'h0807060504030201.
